// File: rtl/cart2600_pkg.sv
// cart2600_pkg: shared types and signature tables for the 2600 cartridge
// scheme detector.
//   bs_e      - bank-switch scheme code reported on force_bs.
//   SIG_*     - packed signature lists. Each pattern is N bytes, with the
//               oldest byte in the most significant position, so "8D E0 1F"
//               is written as 24'h8DE01F.
package cart2600_pkg;

    typedef enum logic [3:0] {
        BS_NONE = 4'd0,
        BS_E0   = 4'd1,
        BS_3F   = 4'd2,
        BS_FE   = 4'd3,
        BS_E7   = 4'd4
    } bs_e;

    // 3F: STA $3F
    localparam int          SIG_3F_N = 2;
    localparam int          SIG_3F_M = 1;
    localparam logic [15:0] SIG_3F   = 16'h853F;

    // E0: hotspot accesses in the $1FE0-$1FF7 range
    localparam int          SIG_E0_N = 3;
    localparam int          SIG_E0_M = 6;
    localparam logic [143:0] SIG_E0  = {
        24'h8DE01F, 24'h8DE05F, 24'h8DE9FF,
        24'hADE9FF, 24'hADEDFF, 24'hADF3BF
    };

    // E7: hotspot accesses in the $1FE0-$1FEB range
    localparam int          SIG_E7_N = 3;
    localparam int          SIG_E7_M = 7;
    localparam logic [167:0] SIG_E7  = {
        24'hADE2FF, 24'hADE5FF, 24'hADE51F, 24'hADE71F,
        24'h0CE71F, 24'h8DE7FF, 24'h8DE71F
    };

    // FE: characteristic JSR/stack sequences of Activision FE carts
    localparam int          SIG_FE_N = 5;
    localparam int          SIG_FE_M = 4;
    localparam logic [159:0] SIG_FE  = {
        40'h2000D0C6C5, 40'h20C3F8A582,
        40'hD0FB2073FE, 40'h2000F084D6
    };

endpackage

// File: rtl/cart_2600_detector_sig_matcher.sv
// sig_matcher: compares the newest N bytes of the download stream against a
// list of M N-byte patterns.
//   hist  - previous N-1 bytes, oldest in the MSBs.
//   data  - byte arriving this cycle (newest).
//   match - high when {hist, data} equals any pattern; purely combinational,
//           the caller qualifies it with its byte strobe.
module sig_matcher #(
    parameter int               N    = 3,
    parameter int               M    = 1,
    parameter logic [M*N*8-1:0] PATS = '0
) (
    input  logic [(N-1)*8-1:0] hist,
    input  logic [7:0]         data,
    output logic               match
);

    logic [N*8-1:0] cand_s;

    // OR together the equality of every pattern with the candidate window
    always_comb begin
        cand_s = {hist, data};
        match  = 1'b0;
        for (int p = 0; p < M; p++) begin
            match = match | (PATS[p*N*8 +: N*8] == cand_s);
        end
    end

endmodule

// File: rtl/cart_2600_detector.sv
// cart_2600_detector: snoops the cartridge download stream and classifies a
// 2600 ROM image.
//   clk, reset - system clock, synchronous active-high reset.
//   addr       - download byte address (modulo 2^ADDR_W).
//   enable     - one-cycle strobe qualifying addr/data.
//   data       - downloaded byte.
//   force_bs   - detected scheme (bs_e), priority E0 > 3F > FE > E7 > none.
//   sc         - SuperChip RAM present.
module cart_2600_detector
    import cart2600_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              enable,
    input  logic [7:0]        data,
    output logic [3:0]        force_bs,
    output logic              sc
);

    localparam logic [ADDR_W-1:0] SEEN1_ADDR = ADDR_W'(13'h10FF);

    // Four previous bytes; together with the incoming byte they form the
    // five-byte window w4..w0.
    logic [31:0]      hist_q, hist_d, hist_s;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       match_s;
    logic [3:0]       hit_s;
    logic             addr_zero_s;
    logic [7:0]       ref_byte_q, ref_byte_d;
    logic             sc_ok_q, sc_ok_d;
    logic             seen1_q, seen1_d;
    logic             sc_q, sc_d;
    bs_e              force_bs_q, force_bs_d;

    // Counter index: 0 = E0, 1 = 3F, 2 = FE, 3 = E7
    sig_matcher #(.N(SIG_E0_N), .M(SIG_E0_M), .PATS(SIG_E0)) u_match_e0 (
        .hist (hist_s[15:0]), .data (data), .match (match_s[0])
    );
    sig_matcher #(.N(SIG_3F_N), .M(SIG_3F_M), .PATS(SIG_3F)) u_match_3f (
        .hist (hist_s[7:0]), .data (data), .match (match_s[1])
    );
    sig_matcher #(.N(SIG_FE_N), .M(SIG_FE_M), .PATS(SIG_FE)) u_match_fe (
        .hist (hist_s[31:0]), .data (data), .match (match_s[2])
    );
    sig_matcher #(.N(SIG_E7_N), .M(SIG_E7_M), .PATS(SIG_E7)) u_match_e7 (
        .hist (hist_s[15:0]), .data (data), .match (match_s[3])
    );

    // Window: a byte at address 0 starts a new file, so history seen by the
    // matchers is zeroed and no signature can straddle the restart.
    always_comb begin
        addr_zero_s = (addr == '0);
        if (addr_zero_s) begin
            hist_s = 32'h0000_0000;
        end else begin
            hist_s = hist_q;
        end
        if (enable) begin
            hist_d = {hist_s[23:0], data};
        end else begin
            hist_d = hist_q;
        end
    end

    // Saturating hit counters, at most one increment per scheme per byte
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (enable && match_s[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Scheme thresholds and priority encoder; uses the next counter values
    // so the result appears one clock after the deciding byte.
    always_comb begin
        hit_s[0] = (cnt_d[0] != '0);
        hit_s[1] = (cnt_d[1] >= CNT_W'(2));
        hit_s[2] = (cnt_d[2] != '0);
        hit_s[3] = (cnt_d[3] != '0);
        if (hit_s[0]) begin
            force_bs_d = BS_E0;
        end else if (hit_s[1]) begin
            force_bs_d = BS_3F;
        end else if (hit_s[2]) begin
            force_bs_d = BS_FE;
        end else if (hit_s[3]) begin
            force_bs_d = BS_E7;
        end else begin
            force_bs_d = BS_NONE;
        end
    end

    // SuperChip: the first 256 bytes of every 4 KiB bank must equal the byte
    // at address 0 (RAM area filler), and the image must reach 0x10FF.
    always_comb begin
        ref_byte_d = ref_byte_q;
        sc_ok_d    = sc_ok_q;
        seen1_d    = seen1_q;
        if (enable) begin
            if (addr_zero_s) begin
                ref_byte_d = data;
            end else if ((addr[11:8] == 4'h0) && (data != ref_byte_q)) begin
                sc_ok_d = 1'b0;
            end else begin
                sc_ok_d = sc_ok_q;
            end
            if (addr == SEEN1_ADDR) begin
                seen1_d = 1'b1;
            end else begin
                seen1_d = seen1_q;
            end
        end else begin
            ref_byte_d = ref_byte_q;
        end
        sc_d = sc_ok_d && seen1_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q     <= 32'h0000_0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            ref_byte_q <= 8'h00;
            sc_ok_q    <= 1'b1;
            seen1_q    <= 1'b0;
            sc_q       <= 1'b0;
            force_bs_q <= BS_NONE;
        end else begin
            hist_q     <= hist_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ref_byte_q <= ref_byte_d;
            sc_ok_q    <= sc_ok_d;
            seen1_q    <= seen1_d;
            sc_q       <= sc_d;
            force_bs_q <= force_bs_d;
        end
    end

    assign force_bs = force_bs_q;
    assign sc       = sc_q;

endmodule

// File: tb/tb_cart_2600_detector.sv
// tb_cart_2600_detector: scoreboard bench for cart_2600_detector. Expected
// outputs are queued when a byte (or reset) is driven and compared one clock
// later, after the DUT has registered its result.
module tb_cart_2600_detector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] addr = 13'h0000;
    logic        enable = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [3:0]  force_bs;
    logic        sc;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] bs;
        logic       sc;
        bit         chk_sc;
    } exp_t;

    exp_t sb_q[$];

    cart_2600_detector #(.ADDR_W(13), .CNT_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .enable   (enable),
        .data     (data),
        .force_bs (force_bs),
        .sc       (sc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input logic [3:0] bs, input logic esc, input bit chk_sc);
        exp_t e;
        e.tag = tag; e.bs = bs; e.sc = esc; e.chk_sc = chk_sc;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, "/bs"}, force_bs, e.bs);
            if (e.chk_sc) begin
                check_val({e.tag, "/sc"}, {3'b000, sc}, {3'b000, e.sc});
            end
        end
    endtask

    // Drive one byte for one clock; optionally queue and check the result.
    task automatic drive(input logic [12:0] a, input logic [7:0] d, input bit chk,
                         input string tag, input logic [3:0] ebs, input logic esc, input bit chk_sc);
        addr = a; data = d; enable = 1'b1;
        if (chk) push_exp(tag, ebs, esc, chk_sc);
        @(posedge clk); #1;
        enable = 1'b0;
        if (chk) pop_cmp();
    endtask

    task automatic send(input logic [12:0] a, input logic [7:0] d);
        drive(a, d, 1'b0, "", 4'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input string tag, input bit chk);
        reset = 1'b1;
        if (chk) push_exp(tag, 4'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        if (chk) pop_cmp();
    endtask

    initial begin
        #1;
        do_reset("reset0", 1'b1);

        // Uniform NOP image: no scheme detected
        for (int a = 0; a < 8192; a++) begin
            drive(13'(a), 8'hEA, (a == 13'h10FE) || (a == 8191), "nop", 4'd0, 1'b0, (a == 13'h10FE));
        end
        idle(3);
        push_exp("nop_hold", 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1; pop_cmp();

        // 3F needs two hits; result appears one clock after the 3F byte
        do_reset("rst_3f", 1'b0);
        send(13'h0000, 8'hEA);
        send(13'h0001, 8'h85);
        drive(13'h0002, 8'h3F, 1'b1, "3f_once", 4'd0, 1'b0, 1'b0);
        send(13'h0003, 8'hEA);
        drive(13'h0004, 8'h85, 1'b1, "3f_pre", 4'd0, 1'b0, 1'b0);
        drive(13'h0005, 8'h3F, 1'b1, "3f_twice", 4'd2, 1'b0, 1'b0);

        // E0 detected later overrides 3F
        send(13'h0006, 8'h8D);
        send(13'h0007, 8'hE0);
        drive(13'h0008, 8'h1F, 1'b1, "e0_over_3f", 4'd1, 1'b0, 1'b0);

        // E0 first, then 3F twice: E0 still wins
        do_reset("rst_e0", 1'b0);
        send(13'h0100, 8'h8D);
        send(13'h0101, 8'hE0);
        drive(13'h0102, 8'h1F, 1'b1, "e0", 4'd1, 1'b0, 1'b0);
        send(13'h0103, 8'h85); send(13'h0104, 8'h3F);
        send(13'h0105, 8'h85);
        drive(13'h0106, 8'h3F, 1'b1, "e0_prio", 4'd1, 1'b0, 1'b0);

        // A match may not straddle an address-0 restart
        do_reset("rst_wrap", 1'b0);
        send(13'h0010, 8'h85); send(13'h0011, 8'h3F);
        send(13'h1FFF, 8'h85);
        drive(13'h0000, 8'h3F, 1'b1, "wrap", 4'd0, 1'b0, 1'b0);

        // E7 alone, then FE (with idle gaps) overrides it
        do_reset("rst_e7", 1'b0);
        send(13'h0200, 8'hAD); send(13'h0201, 8'hE5);
        drive(13'h0202, 8'h1F, 1'b1, "e7", 4'd4, 1'b0, 1'b0);
        send(13'h0203, 8'h20); idle(2);
        send(13'h0204, 8'h00); idle(1);
        send(13'h0205, 8'hD0); idle(3);
        drive(13'h0206, 8'hC6, 1'b1, "fe_pre", 4'd4, 1'b0, 1'b0);
        idle(2);
        drive(13'h0207, 8'hC5, 1'b1, "fe_over_e7", 4'd3, 1'b0, 1'b0);
        do_reset("rst_after_fe", 1'b1);

        // FE alone, split by idle cycles
        send(13'h0300, 8'h20); idle(1);
        send(13'h0301, 8'h00); idle(1);
        send(13'h0302, 8'hD0); idle(1);
        send(13'h0303, 8'hC6); idle(1);
        drive(13'h0304, 8'hC5, 1'b1, "fe", 4'd3, 1'b0, 1'b0);

        // SuperChip: uniform 0xFF through 0x10FF
        do_reset("rst_sc", 1'b0);
        for (int a = 0; a < 13'h10FF; a++) begin
            drive(13'(a), 8'hFF, (a == 13'h10FE), "sc_pre", 4'd0, 1'b0, 1'b1);
        end
        drive(13'h10FF, 8'hFF, 1'b1, "sc_rise", 4'd0, 1'b1, 1'b1);
        drive(13'h1100, 8'h00, 1'b1, "sc_hold", 4'd0, 1'b1, 1'b1);
        do_reset("rst_after_sc", 1'b1);

        // SuperChip broken by a differing byte in bank 1's first page
        for (int a = 0; a <= 13'h10FF; a++) begin
            drive(13'(a), (a == 13'h1050) ? 8'h00 : 8'hFF, (a == 13'h10FF), "sc_bad", 4'd0, 1'b0, 1'b1);
        end

        // 4 KiB image never reports SuperChip
        do_reset("rst_4k", 1'b0);
        for (int a = 0; a < 4096; a++) begin
            drive(13'(a), 8'hFF, (a == 4095), "sc_4k", 4'd0, 1'b0, 1'b1);
        end

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
